// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache for the 8-bit single-cycle CPU.
// A hit returns the addressed 32-bit word combinationally. A miss stalls the CPU
// through BUSYWAIT while one 16-byte block is refilled from instruction memory.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module instr_cache #(
  parameter int ADDR_WIDTH = 10,
  parameter int INDEX_BITS = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
  input  logic [127:0]          MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`endif
);

  localparam int TAG_W = ADDR_WIDTH - 4 - INDEX_BITS;
  localparam int BLK_W = ADDR_WIDTH - 4;
  localparam int NSETS = 1 << INDEX_BITS;

  // state      | meaning
  // S_IDLE     | serving hits; a miss latches the block address
  // S_MEM_READ | block request outstanding, waiting for MEM_BUSYWAIT low
  // S_UPDATE   | writing the captured block, tag and valid bit
  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

  state_t             state_q, state_d;
  logic               mem_read_q, mem_read_d;
  logic [BLK_W-1:0]   mem_addr_q, mem_addr_d;
  logic [NSETS-1:0]   valid_q, valid_d;
  logic [127:0]       fill_q, fill_d;
  logic [TAG_W-1:0]   tag_q  [NSETS];
  logic [TAG_W-1:0]   tag_d  [NSETS];
  logic [127:0]       data_q [NSETS];
  logic [127:0]       data_d [NSETS];

  logic [TAG_W-1:0]      addr_tag;
  logic [INDEX_BITS-1:0] addr_idx;
  logic [1:0]            addr_word;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  busy;
  logic                  unused_addr_lsb;

  assign addr_tag        = ADDRESS[ADDR_WIDTH-1 -: TAG_W];
  assign addr_idx        = ADDRESS[4 +: INDEX_BITS];
  assign addr_word       = ADDRESS[3:2];
  assign unused_addr_lsb = ^ADDRESS[1:0];

  // The refill writes only through the latched block address, so a CPU
  // address change mid-refill cannot corrupt the line being filled.
  assign fill_idx = mem_addr_q[INDEX_BITS-1:0];
  assign fill_tag = mem_addr_q[BLK_W-1 -: TAG_W];

  // Hit detection is only meaningful while idle; during a refill the CPU stalls.
  assign hit = (state_q == S_IDLE) && READ && valid_q[addr_idx] &&
               (tag_q[addr_idx] == addr_tag);

  assign INSTRUCTION = hit ? data_q[addr_idx][{addr_word, 5'd0} +: 32] : 32'h0;
  // Gated by RESET so the CPU is never stalled while the cache is held in reset.
  assign BUSYWAIT    = busy && RESET;
  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = mem_addr_q;

  // Next-state, refill bookkeeping and stall decode.
  always_comb begin
    state_d    = state_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    fill_d     = fill_q;
    tag_d      = tag_q;
    data_d     = data_q;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (READ && !hit) begin
          busy       = 1'b1;
          mem_addr_d = {addr_tag, addr_idx};
          mem_read_d = 1'b1;
          state_d    = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        busy = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_d     = MEM_READDATA;
          mem_read_d = 1'b0;
          state_d    = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busy              = 1'b1;
        valid_d[fill_idx] = 1'b1;
        tag_d[fill_idx]   = fill_tag;
        data_d[fill_idx]  = fill_q;
        state_d           = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: MEM_READ has its own flop so the request line cannot glitch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Line storage and refill buffer carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        after_update_q, after_update_d;

  // Saturating counters; the hit that completes a refill is counted as a miss only.
  always_comb begin
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    after_update_d = (state_q == S_UPDATE);
    if (hit && !after_update_q && (hit_cnt_q != 16'hFFFF))
      hit_cnt_d = hit_cnt_q + 16'd1;
    if ((state_q == S_IDLE) && (state_d == S_MEM_READ) && (miss_cnt_q != 16'hFFFF))
      miss_cnt_d = miss_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      after_update_q <= 1'b0;
    end else begin
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      after_update_q <= after_update_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
